// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU function codes, B-operand select and multiplier FSM states.
package ex_pkg;

  localparam logic [4:0] FN_ADD   = 5'd0;
  localparam logic [4:0] FN_SUB   = 5'd1;
  localparam logic [4:0] FN_AND   = 5'd2;
  localparam logic [4:0] FN_OR    = 5'd3;
  localparam logic [4:0] FN_XOR   = 5'd4;
  localparam logic [4:0] FN_NOR   = 5'd5;
  localparam logic [4:0] FN_SLL   = 5'd6;
  localparam logic [4:0] FN_SRL   = 5'd7;
  localparam logic [4:0] FN_SRA   = 5'd8;
  localparam logic [4:0] FN_SLT   = 5'd9;
  localparam logic [4:0] FN_ADC   = 5'd10;
  localparam logic [4:0] FN_SBC   = 5'd11;
  localparam logic [4:0] FN_PASSB = 5'd12;
  localparam logic [4:0] FN_MUL   = 5'd16;

  typedef enum logic [1:0] {
    B_RT    = 2'd0,
    B_ADDR  = 2'd1,
    B_SHAMT = 2'd2
  } bsel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU; COut is carry for additions and borrow for subtractions.
module alu_core
  import ex_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int FUNC_W      = 5
) (
  input  logic [WORD_LENGTH-1:0] a,
  input  logic [WORD_LENGTH-1:0] b,
  input  logic [FUNC_W-1:0]      fun,
  input  logic                   cin,
  output logic [WORD_LENGTH-1:0] result,
  output logic                   zero,
  output logic                   cout
);

  localparam int SHW = $clog2(WORD_LENGTH);

  logic [WORD_LENGTH:0] w_sum;
  logic [SHW-1:0]       w_shamt;
  logic                 w_defined;

  always_comb begin
    w_sum     = '0;
    result    = '0;
    cout      = 1'b0;
    w_defined = 1'b1;
    w_shamt   = b[SHW-1:0];
    case (fun)
      FUNC_W'(FN_ADD): begin
        w_sum  = {1'b0, a} + {1'b0, b};
        result = w_sum[WORD_LENGTH-1:0];
        cout   = w_sum[WORD_LENGTH];
      end
      FUNC_W'(FN_SUB): begin
        w_sum  = {1'b0, a} - {1'b0, b};
        result = w_sum[WORD_LENGTH-1:0];
        cout   = w_sum[WORD_LENGTH];
      end
      FUNC_W'(FN_ADC): begin
        w_sum  = {1'b0, a} + {1'b0, b} + {{WORD_LENGTH{1'b0}}, cin};
        result = w_sum[WORD_LENGTH-1:0];
        cout   = w_sum[WORD_LENGTH];
      end
      FUNC_W'(FN_SBC): begin
        w_sum  = {1'b0, a} - {1'b0, b} - {{WORD_LENGTH{1'b0}}, cin};
        result = w_sum[WORD_LENGTH-1:0];
        cout   = w_sum[WORD_LENGTH];
      end
      FUNC_W'(FN_AND):   result = a & b;
      FUNC_W'(FN_OR):    result = a | b;
      FUNC_W'(FN_XOR):   result = a ^ b;
      FUNC_W'(FN_NOR):   result = ~(a | b);
      FUNC_W'(FN_SLL):   result = a << w_shamt;
      FUNC_W'(FN_SRL):   result = a >> w_shamt;
      FUNC_W'(FN_SRA):   result = $signed(a) >>> w_shamt;
      FUNC_W'(FN_SLT):   result = WORD_LENGTH'($signed(a) < $signed(b));
      FUNC_W'(FN_PASSB): result = b;
      default:           w_defined = 1'b0;
    endcase
    // Undefined codes must leave both flags low, so zero is qualified too.
    zero = w_defined && (result == '0);
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage with operand forwarding, single-cycle ALU, iterative shift-add multiplier
// and the EX/MEM pipeline register it forwards from.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int WORD_LENGTH  = 8,
  parameter int REG_ADDR_W   = 3,
  parameter int FUNC_W       = 5,
  parameter int R0_HARDWIRED = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inValid,
  input  logic                   flush,
  input  logic                   memStall,
  input  logic [FUNC_W-1:0]      funcIn,
  input  logic                   CIn,
  input  logic                   regWriteIn,
  input  logic [1:0]             selAddrOrDataOrShift,
  input  logic [REG_ADDR_W-1:0]  RsIn,
  input  logic [REG_ADDR_W-1:0]  RtIn,
  input  logic [REG_ADDR_W-1:0]  RdIn,
  input  logic [WORD_LENGTH-1:0] regReadData1In,
  input  logic [WORD_LENGTH-1:0] regReadData2In,
  input  logic [WORD_LENGTH-1:0] pureAddr,
  input  logic                   MEM_WB_regWrite,
  input  logic [REG_ADDR_W-1:0]  MEM_WB_Rd,
  input  logic [WORD_LENGTH-1:0] MEM_WB_data,
  output logic                   stallReq,
  output logic                   outValid,
  output logic                   regWriteOut,
  output logic [REG_ADDR_W-1:0]  RdOut,
  output logic [WORD_LENGTH-1:0] ALUResOut,
  output logic [WORD_LENGTH-1:0] writeDataOut,
  output logic                   zeroOut,
  output logic                   COut
);

  localparam int CNT_W = $clog2(WORD_LENGTH + 1);

  state_e                  r_state, w_nextState;
  logic [CNT_W-1:0]        r_cnt;
  logic [2*WORD_LENGTH-1:0] r_mcand, r_prod;
  logic [WORD_LENGTH-1:0]  r_mplier;
  logic [REG_ADDR_W-1:0]   r_mulRd;
  logic                    r_mulRegWrite;

  logic w_exHitA, w_exHitB, w_wbHitA, w_wbHitB, w_zeroA, w_zeroB;
  logic [WORD_LENGTH-1:0] w_opA, w_fwdRt, w_opB, w_aluRes;
  logic w_aluZero, w_aluCout, w_isMul, w_accept, w_loadProd;

  assign w_zeroA  = (R0_HARDWIRED != 0) && (RsIn == '0);
  assign w_zeroB  = (R0_HARDWIRED != 0) && (RtIn == '0);
  assign w_exHitA = outValid && regWriteOut && (RdOut == RsIn) && !w_zeroA;
  assign w_exHitB = outValid && regWriteOut && (RdOut == RtIn) && !w_zeroB;
  assign w_wbHitA = MEM_WB_regWrite && (MEM_WB_Rd == RsIn) && !w_zeroA;
  assign w_wbHitB = MEM_WB_regWrite && (MEM_WB_Rd == RtIn) && !w_zeroB;

  assign w_opA   = w_exHitA ? ALUResOut : (w_wbHitA ? MEM_WB_data : regReadData1In);
  assign w_fwdRt = w_exHitB ? ALUResOut : (w_wbHitB ? MEM_WB_data : regReadData2In);

  always_comb begin
    w_opB = '0;
    case (bsel_e'(selAddrOrDataOrShift))
      B_RT:    w_opB = w_fwdRt;
      B_ADDR:  w_opB = pureAddr;
      B_SHAMT: w_opB = WORD_LENGTH'(RtIn);
      default: w_opB = '0;
    endcase
  end

  alu_core #(
    .WORD_LENGTH(WORD_LENGTH),
    .FUNC_W     (FUNC_W)
  ) u_alu (
    .a     (w_opA),
    .b     (w_opB),
    .fun   (funcIn),
    .cin   (CIn),
    .result(w_aluRes),
    .zero  (w_aluZero),
    .cout  (w_aluCout)
  );

  assign w_isMul  = (funcIn == FUNC_W'(FN_MUL));
  assign w_accept = inValid && w_isMul && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_nextState = MUL_BUSY;
      MUL_BUSY: if (flush) w_nextState = IDLE;
                else if (r_cnt == CNT_W'(1)) w_nextState = MUL_DONE;
      MUL_DONE: if (flush || !memStall) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  always_comb begin
    stallReq   = 1'b0;
    w_loadProd = 1'b0;
    case (r_state)
      IDLE:     stallReq = w_accept;
      MUL_BUSY: stallReq = !flush;
      MUL_DONE: begin
        stallReq   = memStall && !flush;
        w_loadProd = !memStall && !flush;
      end
      default:  stallReq = 1'b0;
    endcase
    // ID/EX may still present the multiply while reset is asserted; keep the request quiet.
    if (rst) stallReq = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_prod        <= '0;
      r_cnt         <= '0;
      r_mulRd       <= '0;
      r_mulRegWrite <= 1'b0;
    end else if (r_state == IDLE && w_accept) begin
      r_mcand       <= {{WORD_LENGTH{1'b0}}, w_opA};
      r_mplier      <= w_opB;
      r_prod        <= '0;
      r_cnt         <= CNT_W'(WORD_LENGTH);
      r_mulRd       <= RdIn;
      r_mulRegWrite <= regWriteIn;
    end else if (r_state == MUL_BUSY && !flush) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  // EX/MEM register: a finished product takes precedence, otherwise only an IDLE non-MUL op loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid     <= 1'b0;
      regWriteOut  <= 1'b0;
      RdOut        <= '0;
      ALUResOut    <= '0;
      writeDataOut <= '0;
      zeroOut      <= 1'b0;
      COut         <= 1'b0;
    end else if (!memStall) begin
      if (w_loadProd) begin
        outValid     <= 1'b1;
        regWriteOut  <= r_mulRegWrite;
        RdOut        <= r_mulRd;
        ALUResOut    <= r_prod[WORD_LENGTH-1:0];
        writeDataOut <= '0;
        zeroOut      <= (r_prod[WORD_LENGTH-1:0] == '0);
        COut         <= |r_prod[2*WORD_LENGTH-1:WORD_LENGTH];
      end else if (r_state == IDLE && inValid && !flush && !w_isMul) begin
        outValid     <= 1'b1;
        regWriteOut  <= regWriteIn;
        RdOut        <= RdIn;
        ALUResOut    <= w_aluRes;
        writeDataOut <= w_fwdRt;
        zeroOut      <= w_aluZero;
        COut         <= w_aluCout;
      end else begin
        outValid     <= 1'b0;
        regWriteOut  <= 1'b0;
        RdOut        <= '0;
        ALUResOut    <= '0;
        writeDataOut <= '0;
        zeroOut      <= 1'b0;
        COut         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: vector table for single-cycle ops, hand sequences for multiply corners.
module tb_ex_stage_mc;
  import ex_pkg::*;

  logic       clk, rst;
  logic       inValid, flush, memStall, CIn, regWriteIn;
  logic [4:0] funcIn;
  logic [1:0] selAddrOrDataOrShift;
  logic [2:0] RsIn, RtIn, RdIn, MEM_WB_Rd, RdOut;
  logic [7:0] regReadData1In, regReadData2In, pureAddr, MEM_WB_data;
  logic       MEM_WB_regWrite;
  logic       stallReq, outValid, regWriteOut, zeroOut, COut;
  logic [7:0] ALUResOut, writeDataOut;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    logic       inValid, flush, memStall, cin, regWrite;
    logic [4:0] func;
    logic [1:0] selB;
    logic [2:0] rs, rt, rd;
    logic [7:0] d1, d2, addr;
    logic       wbWe;
    logic [2:0] wbRd;
    logic [7:0] wbData;
    logic       expValid, expRegWrite, chkData, expZero, expCout;
    logic [2:0] expRd;
    logic [7:0] expRes, expWdata;
  } vec_t;

  vec_t vecs[$];

  ex_stage_mc #(
    .WORD_LENGTH(8), .REG_ADDR_W(3), .FUNC_W(5), .R0_HARDWIRED(1)
  ) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .flush(flush), .memStall(memStall),
    .funcIn(funcIn), .CIn(CIn), .regWriteIn(regWriteIn),
    .selAddrOrDataOrShift(selAddrOrDataOrShift),
    .RsIn(RsIn), .RtIn(RtIn), .RdIn(RdIn),
    .regReadData1In(regReadData1In), .regReadData2In(regReadData2In), .pureAddr(pureAddr),
    .MEM_WB_regWrite(MEM_WB_regWrite), .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_data(MEM_WB_data),
    .stallReq(stallReq), .outValid(outValid), .regWriteOut(regWriteOut), .RdOut(RdOut),
    .ALUResOut(ALUResOut), .writeDataOut(writeDataOut), .zeroOut(zeroOut), .COut(COut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t stim(input logic [4:0] f, input logic [1:0] sb,
                                input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                                input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] ad,
                                input logic rw, input logic cin);
    vec_t v;
    v.inValid = 1'b1; v.flush = 1'b0; v.memStall = 1'b0;
    v.func = f; v.selB = sb; v.rs = rs; v.rt = rt; v.rd = rd;
    v.d1 = d1; v.d2 = d2; v.addr = ad; v.regWrite = rw; v.cin = cin;
    v.wbWe = 1'b0; v.wbRd = '0; v.wbData = '0;
    v.expValid = 1'b0; v.expRegWrite = 1'b0; v.chkData = 1'b0;
    v.expRd = '0; v.expRes = '0; v.expWdata = '0; v.expZero = 1'b0; v.expCout = 1'b0;
    return v;
  endfunction

  function automatic vec_t expOut(input vec_t vin, input logic ev, input logic erw,
                                  input logic [2:0] erd, input logic [7:0] eres,
                                  input logic [7:0] ewd, input logic ez, input logic ec);
    vec_t v = vin;
    v.expValid = ev; v.expRegWrite = erw; v.chkData = ev;
    v.expRd = erd; v.expRes = eres; v.expWdata = ewd; v.expZero = ez; v.expCout = ec;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    inValid = v.inValid; flush = v.flush; memStall = v.memStall;
    funcIn = v.func; CIn = v.cin; regWriteIn = v.regWrite; selAddrOrDataOrShift = v.selB;
    RsIn = v.rs; RtIn = v.rt; RdIn = v.rd;
    regReadData1In = v.d1; regReadData2In = v.d2; pureAddr = v.addr;
    MEM_WB_regWrite = v.wbWe; MEM_WB_Rd = v.wbRd; MEM_WB_data = v.wbData;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    nChecks++;
    if (act === req) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic applyIdle();
    vec_t v;
    v = stim(FN_ADD, 2'd0, 3'd0, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    v.inValid = 1'b0;
    applyStimulus(v);
  endtask

  // Issue a multiply, count stall cycles, then check the product once it lands in EX/MEM.
  task automatic runMul(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] rd, input logic [7:0] expLo, input logic expC);
    int cnt;
    applyStimulus(stim(FN_MUL, 2'd0, 3'd1, 3'd2, rd, x, y, 8'd0, 1'b1, 1'b0));
    #1;
    cnt = 0;
    for (int c = 0; c < 30 && stallReq; c++) begin
      cnt++;
      @(posedge clk); #1;
    end
    checkOutput({tag, ".stallCycles"}, 16'(cnt), 16'd9);
    checkOutput({tag, ".validInDone"}, 16'(outValid), 16'd0);
    @(posedge clk); #1;
    applyIdle();
    checkOutput({tag, ".valid"}, 16'(outValid), 16'd1);
    checkOutput({tag, ".rd"},    16'(RdOut), 16'(rd));
    checkOutput({tag, ".lo"},    16'(ALUResOut), 16'(expLo));
    checkOutput({tag, ".cout"},  16'(COut), 16'(expC));
    checkOutput({tag, ".zero"},  16'(zeroOut), 16'(expLo == 8'd0));
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    applyIdle();
    #3;
    checkOutput("reset.valid", 16'(outValid), 16'd0);
    checkOutput("reset.res",   16'(ALUResOut), 16'd0);
    checkOutput("reset.stall", 16'(stallReq), 16'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    vecs.push_back(expOut(stim(FN_ADD, 2'd0, 3'd1, 3'd2, 3'd3, 8'd5, 8'd3, 8'd0, 1'b1, 1'b0),
                          1, 1, 3'd3, 8'd8, 8'd3, 0, 0));
    vecs.push_back(expOut(stim(FN_SUB, 2'd0, 3'd3, 3'd1, 3'd4, 8'd0, 8'd5, 8'd0, 1'b1, 1'b0),
                          1, 1, 3'd4, 8'd3, 8'd5, 0, 0));
    vecs.push_back(expOut(stim(FN_ADD, 2'd1, 3'd1, 3'd0, 3'd2, 8'd5, 8'd0, 8'd4, 1'b1, 1'b0),
                          1, 1, 3'd2, 8'd9, 8'd0, 0, 0));
    v = stim(FN_OR, 2'd0, 3'd1, 3'd2, 3'd5, 8'd0, 8'd3, 8'd0, 1'b1, 1'b0);
    v.wbWe = 1'b1; v.wbRd = 3'd2; v.wbData = 8'd7;
    vecs.push_back(expOut(v, 1, 1, 3'd5, 8'd9, 8'd9, 0, 0));
    v = stim(FN_ADD, 2'd0, 3'd0, 3'd1, 3'd6, 8'd0, 8'd2, 8'd0, 1'b1, 1'b0);
    v.wbWe = 1'b1; v.wbRd = 3'd0; v.wbData = 8'd7;
    vecs.push_back(expOut(v, 1, 1, 3'd6, 8'd2, 8'd2, 0, 0));
    vecs.push_back(expOut(stim(FN_SUB, 2'd0, 3'd1, 3'd2, 3'd1, 8'd3, 8'd5, 8'd0, 1'b1, 1'b0),
                          1, 1, 3'd1, 8'hFE, 8'd5, 0, 1));
    vecs.push_back(expOut(stim(FN_XOR, 2'd0, 3'd2, 3'd3, 3'd2, 8'h5A, 8'h5A, 8'd0, 1'b0, 1'b0),
                          1, 0, 3'd2, 8'h00, 8'h5A, 1, 0));
    vecs.push_back(expOut(stim(FN_SLL, 2'd2, 3'd1, 3'd3, 3'd7, 8'h11, 8'h44, 8'd0, 1'b1, 1'b0),
                          1, 1, 3'd7, 8'h88, 8'h44, 0, 0));
    vecs.push_back(expOut(stim(FN_SRA, 2'd1, 3'd1, 3'd0, 3'd7, 8'h88, 8'h00, 8'h0A, 1'b1, 1'b0),
                          1, 1, 3'd7, 8'hE2, 8'h00, 0, 0));
    vecs.push_back(expOut(stim(FN_ADC, 2'd0, 3'd1, 3'd2, 3'd7, 8'hFF, 8'h00, 8'd0, 1'b1, 1'b1),
                          1, 1, 3'd7, 8'h00, 8'h00, 1, 1));
    vecs.push_back(expOut(stim(5'd31, 2'd0, 3'd1, 3'd2, 3'd3, 8'd5, 8'd3, 8'd0, 1'b1, 1'b0),
                          1, 1, 3'd3, 8'h00, 8'd3, 0, 0));
    v = stim(FN_ADD, 2'd0, 3'd1, 3'd2, 3'd3, 8'd1, 8'd1, 8'd0, 1'b1, 1'b0);
    v.inValid = 1'b0;
    vecs.push_back(expOut(v, 0, 0, 3'd0, 8'd0, 8'd0, 0, 0));
    v = stim(FN_ADD, 2'd0, 3'd1, 3'd2, 3'd3, 8'd1, 8'd1, 8'd0, 1'b1, 1'b0);
    v.flush = 1'b1;
    vecs.push_back(expOut(v, 0, 0, 3'd0, 8'd0, 8'd0, 0, 0));
    vecs.push_back(expOut(stim(FN_ADD, 2'd0, 3'd1, 3'd2, 3'd3, 8'd1, 8'd2, 8'd0, 1'b1, 1'b0),
                          1, 1, 3'd3, 8'd3, 8'd2, 0, 0));
    v = stim(FN_SUB, 2'd0, 3'd1, 3'd2, 3'd4, 8'd9, 8'd1, 8'd0, 1'b1, 1'b0);
    v.memStall = 1'b1;
    vecs.push_back(expOut(v, 1, 1, 3'd3, 8'd3, 8'd2, 0, 0));
    vecs.push_back(expOut(stim(FN_SUB, 2'd0, 3'd1, 3'd2, 3'd4, 8'd9, 8'd1, 8'd0, 1'b1, 1'b0),
                          1, 1, 3'd4, 8'd8, 8'd1, 0, 0));
    v = stim(FN_AND, 2'd0, 3'd1, 3'd2, 3'd5, 8'hF0, 8'h00, 8'd0, 1'b1, 1'b0);
    v.wbWe = 1'b1; v.wbRd = 3'd2; v.wbData = 8'h3C;
    vecs.push_back(expOut(v, 1, 1, 3'd5, 8'h30, 8'h3C, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d.stall", i), 16'(stallReq), 16'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d.valid", i), 16'(outValid), 16'(vecs[i].expValid));
      checkOutput($sformatf("v%0d.regWrite", i), 16'(regWriteOut), 16'(vecs[i].expRegWrite));
      if (vecs[i].chkData) begin
        checkOutput($sformatf("v%0d.rd", i),    16'(RdOut), 16'(vecs[i].expRd));
        checkOutput($sformatf("v%0d.res", i),   16'(ALUResOut), 16'(vecs[i].expRes));
        checkOutput($sformatf("v%0d.wdata", i), 16'(writeDataOut), 16'(vecs[i].expWdata));
        checkOutput($sformatf("v%0d.zero", i),  16'(zeroOut), 16'(vecs[i].expZero));
        checkOutput($sformatf("v%0d.cout", i),  16'(COut), 16'(vecs[i].expCout));
      end
    end

    runMul("mul13x11", 8'd13, 8'd11, 3'd5, 8'h8F, 1'b0);
    runMul("mul20x20", 8'd20, 8'd20, 3'd6, 8'h90, 1'b1);

    // Flush on the fourth busy cycle: stall drops at once and no product appears.
    applyStimulus(stim(FN_MUL, 2'd0, 3'd1, 3'd2, 3'd2, 8'd3, 8'd3, 8'd0, 1'b1, 1'b0));
    #1;
    checkOutput("flush.acceptStall", 16'(stallReq), 16'd1);
    @(posedge clk); #1;
    checkOutput("flush.acceptBubble", 16'(outValid), 16'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flush.busyStall", 16'(stallReq), 16'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush.stallDrop", 16'(stallReq), 16'd0);
    @(posedge clk); #1;
    applyStimulus(stim(FN_ADD, 2'd0, 3'd1, 3'd2, 3'd3, 8'd4, 8'd6, 8'd0, 1'b1, 1'b0));
    checkOutput("flush.noValid", 16'(outValid), 16'd0);
    #1;
    checkOutput("flush.addNoStall", 16'(stallReq), 16'd0);
    @(posedge clk); #1;
    checkOutput("flush.addValid", 16'(outValid), 16'd1);
    checkOutput("flush.addRes", 16'(ALUResOut), 16'd10);

    // memStall parks the product in MUL_DONE; an async reset then clears everything mid-cycle.
    v = stim(FN_MUL, 2'd0, 3'd1, 3'd2, 3'd1, 8'd2, 8'd3, 8'd0, 1'b1, 1'b0);
    v.memStall = 1'b1;
    applyStimulus(v);
    repeat (9) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("done%0d.stall", k), 16'(stallReq), 16'd1);
      checkOutput($sformatf("done%0d.held", k), 16'(ALUResOut), 16'd10);
      if (k < 2) begin
        @(posedge clk); #1;
      end
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRst.valid",    16'(outValid), 16'd0);
    checkOutput("asyncRst.regWrite", 16'(regWriteOut), 16'd0);
    checkOutput("asyncRst.res",      16'(ALUResOut), 16'd0);
    checkOutput("asyncRst.rd",       16'(RdOut), 16'd0);
    checkOutput("asyncRst.stall",    16'(stallReq), 16'd0);
    applyIdle();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(stim(FN_ADD, 2'd0, 3'd1, 3'd2, 3'd3, 8'd2, 8'd2, 8'd0, 1'b1, 1'b0));
    #1;
    checkOutput("postRst.stall", 16'(stallReq), 16'd0);
    @(posedge clk); #1;
    checkOutput("postRst.valid", 16'(outValid), 16'd1);
    checkOutput("postRst.res",   16'(ALUResOut), 16'd4);
    applyIdle();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
